shift_arbiter: RTL
==================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_data  in  32  operand.
- req0_shamt  in  5  shift amount.
- req0_ctrl  in  2  op: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_ctrl: same widths and meanings for requester 1.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes result when high with rsp_valid.
- rsp_id  out  1  index of requester that owns the result.
- rsp_result  out  32  shifted result.
- busy  out  1  rsp_valid OR any req valid.
- grant_cnt0, grant_cnt1  out  16  saturating count of accepted operations per requester.

Function
REQ-002 SHALL share one combinational shifter between two requesters through a one-entry registered result slot.
REQ-003 Slot free = !rsp_valid OR rsp_ready, evaluated combinationally in the same cycle.
REQ-004 Arbitration SHALL be round-robin on a 1-bit last-grant pointer:
- only one valid: grant it;
- both valid: grant the requester not equal to last-grant.
REQ-005 reqX_ready SHALL be high only when the slot is free AND X is granted; it is never high for a non-granted requester.
REQ-006 reqX_ready SHALL NOT depend on rsp_result or rsp_id.
REQ-007 Acceptance (valid AND ready) in cycle N SHALL produce a result with rsp_valid=1 in cycle N+1; latency is exactly 1.
REQ-008 On acceptance, the block SHALL register:
- rsp_result = op(data, shamt);
- rsp_id = granted index;
- last-grant = granted index.
REQ-009 Shift semantics:
- SLL: logical left shift.
- SRL: logical right shift.
- SRA: arithmetic right shift replicating bit 31.
- 11: data unchanged.
- shamt 0: data unchanged for all ops.
REQ-010 While rsp_valid=1 and rsp_ready=0, rsp_result and rsp_id SHALL be held stable and both reqX_ready SHALL be 0.
REQ-011 When rsp_ready=1 and a new acceptance occurs in the same cycle, the slot SHALL be overwritten with the new result, rsp_valid stays 1, and there is no bubble.
REQ-012 When rsp_ready=1 with no acceptance, rsp_valid SHALL clear next cycle.
REQ-013 last-grant SHALL update only on acceptance; a requester that drops valid without being accepted does not change it.
REQ-014 grant_cntX SHALL increment on each acceptance from X and saturate at 16'hFFFF.
REQ-015 Throughput: with rsp_ready held 1 and both requesters always valid, grants SHALL alternate 0,1,0,1,... at one acceptance per cycle.

Reset
REQ-016 While rst_n=0, the block SHALL asynchronously force:
- rsp_valid=0, rsp_id=0, rsp_result=0;
- last-grant=1, so requester 0 wins the first contention;
- grant_cnt0=grant_cnt1=0.
REQ-017 A result held in the slot when reset is asserted mid-operation SHALL be discarded, with no rsp_valid after reset release.
REQ-018 After rst_n deasserts, reqX_ready MAY assert in the first clock cycle.

Structure
REQ-019 Shared package shift_pkg SHALL hold:
- op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_PASS=2'b11;
- the XLEN32 width constant;
- the counter width constant (16).
REQ-020 The shift datapath SHALL be one instance of the existing combinational 32-bit shifter sub-module Shifter, with operand muxes selecting the granted request; no second shifter copy.

Verification
REQ-021 Bench SHALL cover:
- Only req0 valid, data=32'h8000_0001, shamt=4, ctrl=10, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=32'hF800_0000.
- Both valid from reset: req0 SRL 32'hF000_0000>>28, req1 SLL 32'h1<<31 -> cycle 1 rsp_result=32'h0000_000F with id 0; cycle 2 rsp_result=32'h8000_0000 with id 1.
- rsp_ready=0 for 3 cycles with result 32'h1234_5678 held -> result and id stable, both ready=0, no acceptance; rsp_ready=1 -> next acceptance in the same cycle, no bubble.
- rst_n pulsed low mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately, counters 0, next contention granted to requester 0.
- Saturation: preload via 65535 req1 acceptances -> grant_cnt1=16'hFFFF, and it stays FFFF after one more acceptance.
- ctrl=11 and shamt=0 with each ctrl on 32'hDEAD_BEEF -> rsp_result=32'hDEAD_BEEF in all cases.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: operation encodings and widths.
package shift_pkg;

    localparam int unsigned XLEN32 = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } sh_op_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 32-bit shifter: logical left/right, arithmetic right, or pass-through.
module Shifter
    import shift_pkg::*;
(
    input  logic [XLEN32-1:0] data,
    input  logic [4:0]        shamt,
    input  logic [1:0]        ctrl,
    output logic [XLEN32-1:0] result
);

    sh_op_e op;

    always_comb begin
        op     = sh_op_e'(ctrl);
        result = data;
        case (op)
            SH_SLL:  result = data << shamt;
            SH_SRL:  result = data >> shamt;
            SH_SRA:  result = $unsigned($signed(data) >>> shamt);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one shifter through a one-entry result slot.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN32-1:0] req0_data,
    input  logic [4:0]        req0_shamt,
    input  logic [1:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN32-1:0] req1_data,
    input  logic [4:0]        req1_shamt,
    input  logic [1:0]        req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN32-1:0] rsp_result,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    logic              last_grant;
    logic              slot_free;
    logic              any_valid;
    logic              gnt_id;
    logic              accept;
    logic [XLEN32-1:0] sh_data;
    logic [4:0]        sh_shamt;
    logic [1:0]        sh_ctrl;
    logic [XLEN32-1:0] sh_result;

    // Grant depends only on request valids and the pointer, never on slot contents.
    always_comb begin
        slot_free = !rsp_valid || rsp_ready;
        any_valid = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = !req0_valid;
        end
        accept     = any_valid && slot_free;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sh_data    = gnt_id ? req1_data  : req0_data;
        sh_shamt   = gnt_id ? req1_shamt : req0_shamt;
        sh_ctrl    = gnt_id ? req1_ctrl  : req0_ctrl;
        busy       = rsp_valid || any_valid;
    end

    Shifter u_shifter (
        .data   (sh_data),
        .shamt  (sh_shamt),
        .ctrl   (sh_ctrl),
        .result (sh_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= gnt_id;
                rsp_result <= sh_result;
                last_grant <= gnt_id;
                if (!gnt_id && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
                if (gnt_id && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
